// File: rtl/neander_pkg.sv
// Shared types for the Neander control unit: opcodes, ULA operations, FSM states
// and the datapath mux-select encodings.
package neander_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_STA = 4'h1,
      OP_LDA = 4'h2,
      OP_ADD = 4'h3,
      OP_OR  = 4'h4,
      OP_AND = 4'h5,
      OP_NOT = 4'h6,
      OP_JMP = 4'h8,
      OP_JN  = 4'h9,
      OP_JZ  = 4'hA,
      OP_HLT = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      ULA_ADD  = 3'b000,
      ULA_AND  = 3'b001,
      ULA_OR   = 3'b010,
      ULA_NOT  = 3'b011,
      ULA_PASS = 3'b100
   } ula_op_t;

   typedef enum logic [4:0] {
      ST_F0, ST_F1, ST_F2, ST_DEC,
      ST_X0,
      ST_A0, ST_A1, ST_A2, ST_A3, ST_A4,
      ST_S3, ST_S4,
      ST_J0, ST_J1, ST_J2, ST_JSKIP,
      ST_HALT, ST_WAIT
   } state_t;

   localparam logic REM_SRC_PC  = 1'b0;
   localparam logic REM_SRC_RDM = 1'b1;
   localparam logic RDM_SRC_MEM = 1'b0;
   localparam logic RDM_SRC_AC  = 1'b1;

   // ULA operation applied in the final step of a memory-operand instruction.
   function automatic ula_op_t ula_for(input opcode_t op);
      case (op)
         OP_ADD:  return ULA_ADD;
         OP_OR:   return ULA_OR;
         OP_AND:  return ULA_AND;
         default: return ULA_PASS;
      endcase
   endfunction

endpackage

// File: rtl/neander_control.sv
// Neander control unit: Moore FSM sequencing fetch/decode/execute and driving every
// datapath load, enable and mux select from the latched opcode and the N/Z flags.
module neander_control
   import neander_pkg::*;
#(
   parameter int OPC_W      = 4,
   parameter int MEM_RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [OPC_W-1:0] opcode,
   input  logic             flag_n,
   input  logic             flag_z,
   output logic             pc_load,
   output logic             pc_inc,
   output logic             rem_load,
   output logic             rem_sel,
   output logic             rdm_load,
   output logic             rdm_sel,
   output logic             mem_write,
   output logic             ri_load,
   output logic             ac_load,
   output logic [2:0]       sel_ula,
   output logic             nz_load,
   output logic             halted
);

   localparam bit         HAS_WAIT  = (MEM_RD_LAT > 1);
   localparam logic [1:0] WAIT_INIT = 2'(HAS_WAIT ? MEM_RD_LAT - 2 : 0);

   state_t     state_q, state_d;
   state_t     ret_q, ret_d;
   state_t     tgt;
   opcode_t    op_q, op_d;
   opcode_t    opc;
   logic [1:0] cnt_q, cnt_d;
   logic       rem_step;

   assign opc = opcode_t'(opcode[3:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_F0;
         ret_q   <= ST_F0;
         op_q    <= OP_NOP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      tgt      = state_q;
      rem_step = 1'b0;
      if (en) begin
         case (state_q)
            ST_F0:    begin tgt = ST_F1; rem_step = 1'b1; end
            ST_F1:    tgt = ST_F2;
            ST_F2:    tgt = ST_DEC;
            ST_DEC: begin
               // Opcode and flags are captured here; later flag changes cannot redirect a jump.
               op_d = opc;
               case (opc)
                  OP_NOT:                                tgt = ST_X0;
                  OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND: tgt = ST_A0;
                  OP_JMP:                                tgt = ST_J0;
                  OP_JN:                                 tgt = flag_n ? ST_J0 : ST_JSKIP;
                  OP_JZ:                                 tgt = flag_z ? ST_J0 : ST_JSKIP;
                  OP_HLT:                                tgt = ST_HALT;
                  default:                               tgt = ST_F0;
               endcase
            end
            ST_X0:    tgt = ST_F0;
            ST_A0:    begin tgt = ST_A1; rem_step = 1'b1; end
            ST_A1:    tgt = ST_A2;
            ST_A2:    begin tgt = (op_q == OP_STA) ? ST_S3 : ST_A3; rem_step = 1'b1; end
            ST_A3:    tgt = ST_A4;
            ST_S3:    tgt = ST_S4;
            ST_J0:    begin tgt = ST_J1; rem_step = 1'b1; end
            ST_J1:    tgt = ST_J2;
            ST_A4, ST_S4, ST_J2, ST_JSKIP: tgt = ST_F0;
            ST_WAIT: begin
               if (cnt_q == 2'd0) begin
                  tgt = ret_q;
               end else begin
                  tgt   = ST_WAIT;
                  cnt_d = cnt_q - 2'd1;
               end
            end
            default:  tgt = state_q;
         endcase
         // Any REM load detours through WAIT so the memory has settled before RDM samples it.
         if (rem_step && HAS_WAIT) begin
            state_d = ST_WAIT;
            ret_d   = tgt;
            cnt_d   = WAIT_INIT;
         end else begin
            state_d = tgt;
         end
      end
   end

   always_comb begin
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      rem_load  = 1'b0;
      rem_sel   = REM_SRC_PC;
      rdm_load  = 1'b0;
      rdm_sel   = RDM_SRC_MEM;
      mem_write = 1'b0;
      ri_load   = 1'b0;
      ac_load   = 1'b0;
      sel_ula   = ULA_ADD;
      nz_load   = 1'b0;
      halted    = 1'b0;
      if (en && !rst) begin
         case (state_q)
            ST_F0, ST_A0, ST_J0: rem_load = 1'b1;
            ST_F1, ST_A1: begin
               rdm_load = 1'b1;
               pc_inc   = 1'b1;
            end
            ST_F2:        ri_load = 1'b1;
            ST_X0: begin
               ac_load = 1'b1;
               nz_load = 1'b1;
               sel_ula = ULA_NOT;
            end
            ST_A2: begin
               rem_load = 1'b1;
               rem_sel  = REM_SRC_RDM;
            end
            ST_A3, ST_J1: rdm_load = 1'b1;
            ST_A4: begin
               ac_load = 1'b1;
               nz_load = 1'b1;
               sel_ula = ula_for(op_q);
            end
            ST_S3: begin
               rdm_load = 1'b1;
               rdm_sel  = RDM_SRC_AC;
            end
            ST_S4:        mem_write = 1'b1;
            ST_J2:        pc_load   = 1'b1;
            ST_JSKIP:     pc_inc    = 1'b1;
            ST_HALT:      halted    = 1'b1;
            default:      ;
         endcase
      end
   end

endmodule

// File: tb/tb_neander_control.sv
// Bench for neander_control: two instances (memory latency 1 and 3) each drive a small
// Neander datapath model; an ISA-level interpreter supplies the expected results.
module tb_neander_control;

   typedef struct {
      logic [7:0]  pc;
      logic [3:0]  op;
      logic [15:0] ac;
      logic        n;
      logic        z;
      int          base;
      int          rl;
   } exp_t;

   localparam logic [12:0] F0_V = 13'h0400;
   localparam logic [12:0] A1_V = 13'h0900;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic        prog_we = 1'b0;
   logic [7:0]  prog_addr = '0;
   logic [15:0] prog_data = '0;
   logic        mon_on = 1'b0;

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t sb0[$];
   exp_t sb1[$];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = 1 + 2 * g;

      logic        pc_load, pc_inc, rem_load, rem_sel, rdm_load, rdm_sel;
      logic        mem_write, ri_load, ac_load, nz_load, halted;
      logic [2:0]  sel_ula;
      logic [12:0] strb;

      logic [15:0] mem [256];
      logic [7:0]  pc, rem;
      logic [15:0] rdm, ac, ula, rd, rd_d1, rd_d2;
      logic [3:0]  ri;
      logic        n, z;
      int          cyc;
      int          last_cyc = 0;
      int          viol = 0;
      int          n_pcl = 0;
      int          n_mw = 0;

      neander_control #(.OPC_W(4), .MEM_RD_LAT(LAT)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .opcode    (ri),
         .flag_n    (n),
         .flag_z    (z),
         .pc_load   (pc_load),
         .pc_inc    (pc_inc),
         .rem_load  (rem_load),
         .rem_sel   (rem_sel),
         .rdm_load  (rdm_load),
         .rdm_sel   (rdm_sel),
         .mem_write (mem_write),
         .ri_load   (ri_load),
         .ac_load   (ac_load),
         .sel_ula   (sel_ula),
         .nz_load   (nz_load),
         .halted    (halted)
      );

      assign strb = {pc_load, pc_inc, rem_load, rem_sel, rdm_load, rdm_sel,
                     mem_write, ri_load, ac_load, sel_ula, nz_load};

      always_comb begin
         case (sel_ula)
            3'b000:  ula = ac + rdm;
            3'b001:  ula = ac & rdm;
            3'b010:  ula = ac | rdm;
            3'b011:  ula = ~ac;
            default: ula = rdm;
         endcase
      end

      // Memory read data only becomes valid LAT cycles after REM changes.
      assign rd = (LAT == 1) ? mem[rem] : (LAT == 2) ? rd_d1 : rd_d2;

      always @(posedge clk) begin
         rd_d1 <= mem[rem];
         rd_d2 <= rd_d1;
         if (prog_we) mem[prog_addr] <= prog_data;
         else if (mem_write) mem[rem] <= rdm;
      end

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            pc <= '0; rem <= '0; rdm <= '0; ac <= '0; ri <= '0; n <= 1'b0; z <= 1'b0;
            cyc <= 0;
         end else begin
            if (en) cyc <= cyc + 1;
            if (pc_load) pc <= rdm[7:0];
            else if (pc_inc) pc <= pc + 8'd1;
            if (rem_load) rem <= rem_sel ? rdm[7:0] : pc;
            if (rdm_load) rdm <= rdm_sel ? ac : rd;
            if (ri_load) ri <= rdm[3:0];
            if (ac_load) ac <= ula;
            if (nz_load) begin
               n <= ula[15];
               z <= (ula == 16'h0000);
            end
         end
      end

      always @(negedge clk) begin : mon
         exp_t e;
         logic got_e;
         if (mon_on && !rst) begin
            if ((pc_load && pc_inc) || (mem_write && rdm_load)) viol++;
            if (pc_load) n_pcl++;
            if (mem_write) n_mw++;
            if (ri_load) begin
               got_e = 1'b0;
               if (g == 0) begin
                  if (sb0.size() > 0) begin e = sb0.pop_front(); got_e = 1'b1; end
               end else begin
                  if (sb1.size() > 0) begin e = sb1.pop_front(); got_e = 1'b1; end
               end
               if (!got_e) begin
                  chk($sformatf("i%0d_sb_underflow", g), 0, 1);
               end else begin
                  chk($sformatf("i%0d_pc@%0h", g, e.pc), pc, e.pc);
                  chk($sformatf("i%0d_op@%0h", g, e.pc), rdm[3:0], e.op);
                  chk($sformatf("i%0d_ac@%0h", g, e.pc), ac, e.ac);
                  chk($sformatf("i%0d_nz@%0h", g, e.pc), {n, z}, {e.n, e.z});
                  if (e.base >= 0)
                     chk($sformatf("i%0d_cycles@%0h", g, e.pc), cyc - last_cyc,
                         e.base + (LAT - 1) * e.rl);
               end
               last_cyc = cyc;
            end
         end
      end
   end

   logic [15:0] img [256];
   logic [15:0] m   [256];

   initial begin
      logic [7:0]  ipc, a;
      logic [15:0] iac, exp_ac, exp_m90;
      logic [3:0]  op;
      logic        in_f, iz;
      int          pbase, prl, exp_pcl, exp_mw, bad;
      logic        ok;
      exp_t        e;

      for (int i = 0; i < 256; i++) img[i] = 16'h0000;
      img[8'h00] = 16'h0002; img[8'h01] = 16'h0080;   // LDA 80
      img[8'h02] = 16'h0003; img[8'h03] = 16'h0081;   // ADD 81
      img[8'h04] = 16'h0002; img[8'h05] = 16'h0082;   // LDA 82
      img[8'h06] = 16'h0001; img[8'h07] = 16'h0090;   // STA 90
      img[8'h08] = 16'h0009; img[8'h09] = 16'h0020;   // JN 20
      img[8'h20] = 16'h0002; img[8'h21] = 16'h0083;   // LDA 83
      img[8'h22] = 16'h0009; img[8'h23] = 16'h0040;   // JN 40
      img[8'h24] = 16'h0006;                          // NOT
      img[8'h25] = 16'h000A; img[8'h26] = 16'h0050;   // JZ 50
      img[8'h27] = 16'h0008; img[8'h28] = 16'h0010;   // JMP 10
      img[8'h10] = 16'h0005; img[8'h11] = 16'h0084;   // AND 84
      img[8'h12] = 16'h0004; img[8'h13] = 16'h0085;   // OR 85
      img[8'h14] = 16'h0000;                          // NOP
      img[8'h15] = 16'h0007;                          // undefined
      img[8'h16] = 16'h0002; img[8'h17] = 16'h0083;   // LDA 83
      img[8'h18] = 16'h000A; img[8'h19] = 16'h0030;   // JZ 30
      img[8'h30] = 16'h000F;                          // HLT
      img[8'h80] = 16'h0005; img[8'h81] = 16'h0003; img[8'h82] = 16'hFFFF;
      img[8'h83] = 16'h0000; img[8'h84] = 16'h00F0; img[8'h85] = 16'h0F00;

      // ISA-level reference run builds the scoreboard before the hardware starts.
      for (int i = 0; i < 256; i++) m[i] = img[i];
      ipc = '0; iac = '0; in_f = 1'b0; iz = 1'b0;
      pbase = -1; prl = 0; exp_pcl = 0; exp_mw = 0;
      for (int k = 0; k < 64; k++) begin
         op = m[ipc][3:0];
         a  = m[ipc + 8'd1][7:0];
         e.pc = ipc + 8'd1; e.op = op; e.ac = iac; e.n = in_f; e.z = iz;
         e.base = pbase; e.rl = prl;
         sb0.push_back(e);
         sb1.push_back(e);
         if (op == 4'hF) break;
         case (op)
            4'h1: begin m[a] = iac; ipc += 8'd2; pbase = 9; prl = 3; exp_mw++; end
            4'h2, 4'h3, 4'h4, 4'h5: begin
               case (op)
                  4'h2:    iac = m[a];
                  4'h3:    iac = iac + m[a];
                  4'h4:    iac = iac | m[a];
                  default: iac = iac & m[a];
               endcase
               in_f = iac[15]; iz = (iac == 16'h0000);
               ipc += 8'd2; pbase = 9; prl = 3;
            end
            4'h6: begin
               iac = ~iac; in_f = iac[15]; iz = (iac == 16'h0000);
               ipc += 8'd1; pbase = 5; prl = 1;
            end
            4'h8: begin ipc = a; pbase = 7; prl = 2; exp_pcl++; end
            4'h9, 4'hA: begin
               if ((op == 4'h9) ? in_f : iz) begin
                  ipc = a; pbase = 7; prl = 2; exp_pcl++;
               end else begin
                  ipc += 8'd2; pbase = 5; prl = 1;
               end
            end
            default: begin ipc += 8'd1; pbase = 4; prl = 1; end
         endcase
      end
      exp_ac  = iac;
      exp_m90 = m[8'h90];

      for (int i = 0; i < 256; i++) begin
         prog_addr = 8'(i); prog_data = img[i]; prog_we = 1'b1;
         @(posedge clk); #1;
      end
      prog_we = 1'b0;

      chk("rst_strobes_i0", g_dut[0].strb, 13'h0);
      chk("rst_strobes_i1", g_dut[1].strb, 13'h0);
      chk("rst_halted", {g_dut[0].halted, g_dut[1].halted}, 2'b00);

      mon_on = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("f0_i0", g_dut[0].strb, F0_V);
      chk("f0_i1", g_dut[1].strb, F0_V);

      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = g_dut[0].ri_load; end
      chk("fetch_seen", ok, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = g_dut[0].pc_inc; end
      chk("a1_seen", ok, 1'b1);
      chk("a1_strobes", g_dut[0].strb, A1_V);
      #2 en = 1'b0;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (g_dut[0].strb != 13'h0 || g_dut[1].strb != 13'h0 || g_dut[1].halted) bad++;
      end
      chk("freeze_quiet", bad, 0);
      #2 en = 1'b1;
      #1 chk("a1_resume", g_dut[0].strb, A1_V);

      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         ok = g_dut[0].halted && g_dut[1].halted;
      end
      chk("halt_reached", ok, 1'b1);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!g_dut[0].halted || !g_dut[1].halted) bad++;
         if (g_dut[0].strb != 13'h0 || g_dut[1].strb != 13'h0) bad++;
      end
      chk("halt_hold", bad, 0);

      chk("i0_ac_final", g_dut[0].ac, exp_ac);
      chk("i1_ac_final", g_dut[1].ac, exp_ac);
      chk("i0_mem90", g_dut[0].mem[8'h90], exp_m90);
      chk("i1_mem90", g_dut[1].mem[8'h90], exp_m90);
      chk("i0_pc_load_cnt", g_dut[0].n_pcl, exp_pcl);
      chk("i1_pc_load_cnt", g_dut[1].n_pcl, exp_pcl);
      chk("i0_mem_write_cnt", g_dut[0].n_mw, exp_mw);
      chk("i1_mem_write_cnt", g_dut[1].n_mw, exp_mw);
      chk("i0_conflicts", g_dut[0].viol, 0);
      chk("i1_conflicts", g_dut[1].viol, 0);
      chk("sb_drained", sb0.size() + sb1.size(), 0);

      mon_on = 1'b0;
      #2 rst = 1'b1;
      #1 chk("rst_clears_halt", {g_dut[0].halted, g_dut[1].halted}, 2'b00);
      @(negedge clk);
      #2 rst = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = g_dut[0].rem_load && g_dut[0].rem_sel;
      end
      chk("a2_seen", ok, 1'b1);
      #2 rst = 1'b1;
      #1 chk("rst_mid_a2", g_dut[0].strb, 13'h0);
      @(negedge clk);
      chk("rst_hold", {g_dut[0].strb, g_dut[1].strb}, 26'h0);
      #2 rst = 1'b0;
      #1;
      chk("rst_f0_i0", g_dut[0].strb, F0_V);
      chk("rst_f0_i1", g_dut[1].strb, F0_V);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
